mio_bus_responder: RTL and testbench

- Memory/IO-side responder for the pipelined CPU's data bus.
- Accepts the CPU's requests: request strobe, write enable, address, store data, dm_ctrl width code.
- Drives a word-wide synchronous data RAM, with read-modify-write for byte and halfword stores, plus a small peripheral register window (LEDs, switches, cycle counter).
- Returns sign- or zero-extended load data with a one-cycle ready pulse.

---
 rtl/mio_bus_responder_if.sv | 14 +
 rtl/mio_bus_responder.sv | 178 +++++++++++++++++
 tb/tb_mio_bus_responder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mio_bus_responder_if.sv
// CPU data-bus handshake between the pipeline's memory stage and the MIO responder.
interface mio_bus_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  dm_ctrl;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (output req, we, addr, wdata, dm_ctrl, input rdata, ready, err);
  modport slave  (input req, we, addr, wdata, dm_ctrl, output rdata, ready, err);
endinterface

// File: rtl/mio_bus_responder.sv
// Data-bus responder: word RAM with read-modify-write for sub-word stores,
// plus a LED / switch / cycle-counter register window above IO_BASE.
module mio_bus_responder #(
  parameter int unsigned RAM_AW  = 10,
  parameter logic [31:0] IO_BASE = 32'hFFFF_0000,
  parameter int unsigned LED_W   = 16,
  parameter int unsigned SW_W    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  mio_bus_responder_if.slave    bus,
  output logic [RAM_AW-1:0]     ram_addr_o,
  output logic                  ram_we_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i,
  input  logic [SW_W-1:0]       sw_in_i,
  output logic [LED_W-1:0]      led_out_o
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_RESP} state_t;

  state_t              state_q;
  logic                we_q;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic [2:0]          ctrl_q;
  logic [31:0]         rdata_q;
  logic                ready_q;
  logic                err_q;
  logic                err_pend_q;
  logic [RAM_AW-1:0]   ram_addr_q;
  logic                ram_we_q;
  logic [31:0]         ram_wdata_q;
  logic [LED_W-1:0]    led_q;
  logic [31:0]         cnt_q;
  logic [SW_W-1:0]     sw_meta_q;
  logic [SW_W-1:0]     sw_sync_q;

  logic                is_word;
  logic                is_half;
  logic                is_io;
  logic                acc_err;
  logic [29:0]         io_word;
  logic [31:0]         io_rdata;
  logic [7:0]          byte_lane;
  logic [15:0]         half_lane;
  logic [31:0]         load_data;
  logic [31:0]         merged;

  always_comb begin
    is_word = (ctrl_q == 3'd0);
    is_half = (ctrl_q == 3'd1) || (ctrl_q == 3'd2);
    is_io   = (addr_q >= IO_BASE);
    acc_err = (ctrl_q > 3'd4)
           || (is_word && (addr_q[1:0] != 2'b00))
           || (is_half && addr_q[0])
           || (is_io && !is_word);
    io_word = addr_q[31:2] - IO_BASE[31:2];

    case (io_word)
      30'd0:   io_rdata = 32'(led_q);
      30'd1:   io_rdata = 32'(sw_sync_q);
      30'd2:   io_rdata = cnt_q;
      default: io_rdata = '0;
    endcase

    half_lane = addr_q[1] ? ram_rdata_i[31:16] : ram_rdata_i[15:0];
    byte_lane = ram_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    case (ctrl_q)
      3'd0:    load_data = ram_rdata_i;
      3'd1:    load_data = {{16{half_lane[15]}}, half_lane};
      3'd2:    load_data = {16'h0000, half_lane};
      3'd3:    load_data = {{24{byte_lane[7]}}, byte_lane};
      3'd4:    load_data = {24'h000000, byte_lane};
      default: load_data = '0;
    endcase

    // Read-modify-write: only the addressed lane is replaced.
    merged = ram_rdata_i;
    if (is_half) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ctrl_q      <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      err_pend_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      led_q       <= '0;
      cnt_q       <= '0;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
    end else begin
      sw_meta_q <= sw_in_i;
      sw_sync_q <= sw_meta_q;
      cnt_q     <= cnt_q + 32'd1;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      ram_we_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            we_q       <= bus.we;
            addr_q     <= bus.addr;
            wdata_q    <= bus.wdata;
            ctrl_q     <= bus.dm_ctrl;
            ram_addr_q <= bus.addr[RAM_AW+1:2];
            err_pend_q <= 1'b0;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (acc_err) begin
            rdata_q    <= '0;
            err_pend_q <= 1'b1;
            state_q    <= S_RESP;
          end else if (is_io) begin
            // A CNT write is placed after the increment so the clear wins.
            if (we_q) begin
              case (io_word)
                30'd0:   led_q <= wdata_q[LED_W-1:0];
                30'd2:   cnt_q <= '0;
                default: ;
              endcase
            end else begin
              rdata_q <= io_rdata;
            end
            state_q <= S_RESP;
          end else if (we_q && is_word) begin
            ram_we_q    <= 1'b1;
            ram_wdata_q <= wdata_q;
            state_q     <= S_RESP;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (we_q) begin
            ram_wdata_q <= merged;
            state_q     <= S_WRITE;
          end else begin
            rdata_q <= load_data;
            state_q <= S_RESP;
          end
        end
        S_WRITE: begin
          ram_we_q <= 1'b1;
          state_q  <= S_RESP;
        end
        S_RESP: begin
          ready_q <= 1'b1;
          err_q   <= err_pend_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rdata   = rdata_q;
  assign bus.ready   = ready_q;
  assign bus.err     = err_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_we_o    = ram_we_q;
  assign ram_wdata_o = ram_wdata_q;
  assign led_out_o   = led_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Bench for mio_bus_responder: vector table through a scoreboard, plus
// hand-written reset-abort and cycle-counter sequences.
module tb_mio_bus_responder;

  localparam logic [31:0] IOB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [15:0] sw_in = 16'h8001;
  logic [15:0] led_out;
  logic [31:0] mem [0:1023] = '{default: '0};
  int unsigned cyc = 0;

  mio_bus_responder_if bus_if ();

  mio_bus_responder #(
    .RAM_AW (10),
    .IO_BASE(IOB),
    .LED_W  (16),
    .SW_W   (16)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (bus_if),
    .ram_addr_o (ram_addr),
    .ram_we_o   (ram_we),
    .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata),
    .sw_in_i    (sw_in),
    .led_out_o  (led_out)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    logic [31:0] exp;   // load data, or the RAM word a store must write
    logic        err;
    int unsigned lat;
    int unsigned wes;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned lat;
    int unsigned wes;
    logic [31:0] waddr;
    logic [31:0] wword;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sbq[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] last_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] c, input logic [31:0] ex, input logic er,
                     input int unsigned lat, input int unsigned wes);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = wd; v.ctrl = c;
    v.exp = ex; v.err = er; v.lat = lat; v.wes = wes;
    vecs.push_back(v);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where ready was seen.
  task automatic run_txn(input string tag, input vec_t v, output int unsigned acc);
    exp_t        e;
    exp_t        got_e;
    logic        got;
    int unsigned nwe;
    logic [31:0] wa;
    logic [31:0] ww;
    e.err   = v.err;
    e.lat   = v.lat;
    e.wes   = v.wes;
    e.waddr = {22'd0, v.addr[11:2]};
    e.wword = v.exp;
    if (v.we && !v.err) e.rdata = last_rd;
    else begin
      e.rdata = v.exp;
      last_rd = v.exp;
    end
    sbq.push_back(e);

    bus_if.req     = 1'b1;
    bus_if.we      = v.we;
    bus_if.addr    = v.addr;
    bus_if.wdata   = v.wdata;
    bus_if.dm_ctrl = v.ctrl;
    @(posedge clk);
    #1;
    acc = cyc;
    bus_if.req = 1'b0;

    got = 1'b0; nwe = 0; wa = '0; ww = '0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (bus_if.err && !bus_if.ready) check({tag, " err_without_ready"}, 32'd1, 32'd0);
      if (ram_we) begin
        nwe++;
        wa = {22'd0, ram_addr};
        ww = ram_wdata;
      end
      if (bus_if.ready) begin
        got   = 1'b1;
        got_e = sbq.pop_front();
        check({tag, " rdata"}, bus_if.rdata, got_e.rdata);
        check({tag, " err"}, {31'd0, bus_if.err}, {31'd0, got_e.err});
        check({tag, " latency"}, 32'(i), 32'(got_e.lat));
        check({tag, " ram_we_count"}, 32'(nwe), 32'(got_e.wes));
        if (got_e.wes != 0) begin
          check({tag, " ram_addr"}, wa, got_e.waddr);
          check({tag, " ram_wdata"}, ww, got_e.wword);
        end
      end
    end
    if (!got) begin
      check({tag, " ready_timeout"}, 32'd0, 32'd1);
      void'(sbq.pop_front());
    end
  endtask

  initial begin
    int unsigned acc;
    int unsigned t_wr;
    int unsigned n_rdy;
    int unsigned n_we;
    vec_t        v;

    bus_if.req = 1'b0; bus_if.we = 1'b0; bus_if.addr = '0;
    bus_if.wdata = '0; bus_if.dm_ctrl = '0;

    repeat (3) @(negedge clk);
    check("reset ready", {31'd0, bus_if.ready}, 32'd0);
    check("reset err", {31'd0, bus_if.err}, 32'd0);
    check("reset rdata", bus_if.rdata, 32'd0);
    check("reset ram_we", {31'd0, ram_we}, 32'd0);
    check("reset ram_addr", {22'd0, ram_addr}, 32'd0);
    check("reset ram_wdata", ram_wdata, 32'd0);
    check("reset led", {16'd0, led_out}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    //  we   addr           wdata          ctrl  exp            err  lat wes
    add(1'b1, 32'h0000_0010, 32'h1234_5678, 3'd0, 32'h1234_5678, 1'b0, 2, 1);
    add(1'b0, 32'h0000_0010, 32'h0,         3'd0, 32'h1234_5678, 1'b0, 3, 0);
    add(1'b1, 32'h0000_0012, 32'h0000_00AB, 3'd4, 32'h12AB_5678, 1'b0, 4, 1);
    add(1'b0, 32'h0000_0012, 32'h0,         3'd3, 32'hFFFF_FFAB, 1'b0, 3, 0);
    add(1'b0, 32'h0000_0012, 32'h0,         3'd4, 32'h0000_00AB, 1'b0, 3, 0);
    add(1'b0, 32'h0000_0010, 32'h0,         3'd0, 32'h12AB_5678, 1'b0, 3, 0);
    add(1'b0, 32'h0000_0011, 32'h0,         3'd1, 32'h0,         1'b1, 2, 0);
    add(1'b0, 32'h0000_0012, 32'h0,         3'd0, 32'h0,         1'b1, 2, 0);
    add(1'b0, 32'h0000_0010, 32'h0,         3'd5, 32'h0,         1'b1, 2, 0);
    add(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'd7, 32'h0,         1'b1, 2, 0);
    add(1'b0, 32'h0000_0010, 32'h0,         3'd0, 32'h12AB_5678, 1'b0, 3, 0);
    add(1'b1, 32'h0000_0022, 32'h1234_8765, 3'd2, 32'h8765_0000, 1'b0, 4, 1);
    add(1'b0, 32'h0000_0022, 32'h0,         3'd1, 32'hFFFF_8765, 1'b0, 3, 0);
    add(1'b0, 32'h0000_0022, 32'h0,         3'd2, 32'h0000_8765, 1'b0, 3, 0);
    add(1'b0, 32'h0000_0020, 32'h0,         3'd1, 32'h0000_0000, 1'b0, 3, 0);
    add(1'b1, 32'h0000_0013, 32'h0000_005A, 3'd3, 32'h5AAB_5678, 1'b0, 4, 1);
    add(1'b0, 32'h0000_0010, 32'h0,         3'd0, 32'h5AAB_5678, 1'b0, 3, 0);
    add(1'b0, 32'h0000_0011, 32'h0,         3'd3, 32'h0000_0056, 1'b0, 3, 0);
    add(1'b1, 32'h0000_0011, 32'h0000_0080, 3'd3, 32'h5AAB_8078, 1'b0, 4, 1);
    add(1'b0, 32'h0000_0011, 32'h0,         3'd3, 32'hFFFF_FF80, 1'b0, 3, 0);
    add(1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 3'd0, 32'hCAFE_F00D, 1'b0, 2, 1);
    add(1'b0, 32'hFFFE_FFFC, 32'h0,         3'd0, 32'hCAFE_F00D, 1'b0, 3, 0);
    add(1'b1, IOB + 32'h0,   32'hFFFF_00A5, 3'd0, 32'h0,         1'b0, 2, 0);
    add(1'b0, IOB + 32'h0,   32'h0,         3'd0, 32'h0000_00A5, 1'b0, 2, 0);
    add(1'b0, IOB + 32'h4,   32'h0,         3'd0, 32'h0000_8001, 1'b0, 2, 0);
    add(1'b1, IOB + 32'h4,   32'h1234_5678, 3'd0, 32'h0,         1'b0, 2, 0);
    add(1'b0, IOB + 32'h4,   32'h0,         3'd0, 32'h0000_8001, 1'b0, 2, 0);
    add(1'b0, IOB + 32'hC,   32'h0,         3'd0, 32'h0,         1'b0, 2, 0);
    add(1'b0, 32'hFFFF_FFFC, 32'h0,         3'd0, 32'h0,         1'b0, 2, 0);
    add(1'b1, IOB + 32'h0,   32'h0000_FFFF, 3'd1, 32'h0,         1'b1, 2, 0);
    add(1'b0, IOB + 32'h8,   32'h0,         3'd4, 32'h0,         1'b1, 2, 0);
    add(1'b0, IOB + 32'h0,   32'h0,         3'd0, 32'h0000_00A5, 1'b0, 2, 0);

    foreach (vecs[k]) run_txn($sformatf("vec%0d", k), vecs[k], acc);
    check("led after io writes", {16'd0, led_out}, 32'h0000_00A5);

    // Counter clear then read: value is the increments after the clearing edge.
    add(1'b1, IOB + 32'h8, 32'h0000_1234, 3'd0, 32'h0, 1'b0, 2, 0);
    run_txn("cnt_write", vecs[vecs.size()-1], t_wr);
    repeat (10) @(negedge clk);
    v = vecs[vecs.size()-1];
    v.we = 1'b0; v.wdata = '0;
    v.exp = (cyc + 1) - t_wr - 1;
    run_txn("cnt_read", v, acc);

    // Counter forced to all-ones wraps to 0, then counts 1 by the read's ISSUE cycle.
    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    @(negedge clk);
    v.exp = 32'd1;
    run_txn("cnt_wrap", v, acc);

    // Reset while a byte store sits in WRITE.
    add(1'b1, 32'h0000_0030, 32'h1122_3344, 3'd0, 32'h1122_3344, 1'b0, 2, 1);
    run_txn("pre_reset_sw", vecs[vecs.size()-1], acc);
    bus_if.req = 1'b1; bus_if.we = 1'b1; bus_if.addr = 32'h0000_0031;
    bus_if.wdata = 32'h0000_00EE; bus_if.dm_ctrl = 3'd4;
    @(posedge clk);
    #1 bus_if.req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    n_rdy = 0; n_we = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_if.ready) n_rdy++;
      if (ram_we) n_we++;
    end
    check("abort ready_count", 32'(n_rdy), 32'd0);
    check("abort ram_we_count", 32'(n_we), 32'd0);
    check("abort led", {16'd0, led_out}, 32'd0);
    check("abort rdata", bus_if.rdata, 32'd0);
    check("abort ram_addr", {22'd0, ram_addr}, 32'd0);
    check("abort mem word", mem[12], 32'h1122_3344);
    rst_n = 1'b1;
    last_rd = '0;
    @(negedge clk);
    add(1'b0, 32'h0000_0031, 32'h0, 3'd4, 32'h0000_0033, 1'b0, 3, 0);
    run_txn("post_reset_lbu", vecs[vecs.size()-1], acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
